keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_scanner.sv | 154 +++++++++++++++
 tb/tb_keypad_scanner.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner: column-scanning 4x4 keypad decoder with one sample per dwell,
// press/release debounce and a valid/ack handshake with a sticky overrun flag.
module keypad_scanner #(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ack,
    output logic       key_down,
    output logic       overrun
);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CNT - 1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HOLD, RELEASE} state_t;

    state_t        state, state_n;
    logic [3:0]    rows_m, rows_s;
    logic          run;
    logic [DW-1:0] div_cnt;
    logic [1:0]    col_idx, col_n, row_idx, row_n, row_enc;
    logic [CW-1:0] cnt, cnt_n;
    logic          sample, one_low, all_high, row_match, accept, key_up;

    assign sample    = run && div_cnt == DIV_LAST;
    assign all_high  = rows_s == 4'hF;
    assign one_low   = $countones(~rows_s) == 1;
    assign row_match = rows_s == ~(4'b0001 << row_idx);
    assign cols      = run ? ~(4'b0001 << col_idx) : 4'hF;

    always_comb begin
        row_enc = !rows_s[0] ? 2'd0 : !rows_s[1] ? 2'd1 : !rows_s[2] ? 2'd2 : 2'd3;
    end

    // run marks the first edge after reset, when scanning of column 0 begins
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rows_m  <= '0;
            rows_s  <= '0;
            run     <= 1'b0;
            div_cnt <= '0;
        end else begin
            rows_m <= rows;
            rows_s <= rows_m;
            run    <= 1'b1;
            if (run)
                div_cnt <= sample ? '0 : div_cnt + 1'b1;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        col_n   = col_idx;
        row_n   = row_idx;
        accept  = 1'b0;
        key_up  = 1'b0;
        if (sample) begin
            case (state)
                SCAN: begin
                    if (one_low) begin
                        row_n = row_enc;
                        if (DEBOUNCE_CNT == 1) begin
                            accept  = 1'b1;
                            state_n = HOLD;
                        end else begin
                            state_n = DEBOUNCE;
                            cnt_n   = CW'(1);
                        end
                    end else begin
                        col_n = col_idx + 1'b1;
                    end
                end
                DEBOUNCE: begin
                    if (!row_match) begin
                        state_n = SCAN;
                        col_n   = col_idx + 1'b1;
                    end else if (cnt == CNT_LAST) begin
                        accept  = 1'b1;
                        state_n = HOLD;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (all_high) begin
                        if (DEBOUNCE_CNT == 1) begin
                            key_up  = 1'b1;
                            state_n = SCAN;
                            col_n   = 2'd0;
                        end else begin
                            state_n = RELEASE;
                            cnt_n   = CW'(1);
                        end
                    end
                end
                default: begin
                    if (!all_high) begin
                        state_n = HOLD;
                    end else if (cnt == CNT_LAST) begin
                        key_up  = 1'b1;
                        state_n = SCAN;
                        col_n   = 2'd0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= SCAN;
            cnt     <= '0;
            col_idx <= '0;
            row_idx <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            col_idx <= col_n;
            row_idx <= row_n;
        end
    end

    // overrun can only be set while key_valid is high, so clearing on ack covers it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key_code  <= '0;
            key_valid <= 1'b0;
            key_down  <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (accept) begin
                key_code  <= {row_n, col_idx};
                key_valid <= 1'b1;
                key_down  <= 1'b1;
                overrun   <= key_valid & ~key_ack;
            end else if (key_ack && key_valid) begin
                key_valid <= 1'b0;
                overrun   <= 1'b0;
            end
            if (key_up)
                key_down <= 1'b0;
        end
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed and randomized checks of keypad_scanner against a
// per-sample behavioural model (SCAN_DIV=4, DEBOUNCE_CNT=3).
module tb_keypad_scanner;
    localparam int D = 3;

    logic       clk = 0, reset = 0, key_ack = 0;
    logic [3:0] rows = 4'hF;
    logic [3:0] cols, key_code;
    logic       key_valid, key_down, overrun;
    logic [10:0] obs;
    int n_checks = 0, n_fail = 0;

    int m_state, m_col, m_row, m_cnt;
    logic [3:0] m_code;
    bit m_valid, m_down, m_ovr;

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CNT(D)) dut (
        .clk(clk), .reset(reset), .rows(rows), .cols(cols), .key_code(key_code),
        .key_valid(key_valid), .key_ack(key_ack), .key_down(key_down), .overrun(overrun)
    );

    always #5 clk = ~clk;
    assign obs = {cols, key_code, key_valid, key_down, overrun};

    function automatic logic [3:0] pat(input int i);
        logic [3:0] one = 4'b0001;
        return ~(one << i);
    endfunction

    function automatic logic [10:0] exp_bus();
        return {pat(m_col), m_code, m_valid, m_down, m_ovr};
    endfunction

    // model: states 0 scan, 1 debounce, 2 hold, 3 release; one call per sample
    task automatic m_sample(input logic [3:0] r, input bit a);
        bit acc;
        int nl;
        acc = 0;
        nl = $countones(~r);
        case (m_state)
            0: if (nl == 1) begin
                for (int i = 0; i < 4; i++) if (!r[i]) m_row = i;
                if (D == 1) acc = 1; else begin m_state = 1; m_cnt = 1; end
            end else m_col = (m_col + 1) % 4;
            1: if (nl == 1 && !r[m_row]) begin
                m_cnt++;
                if (m_cnt == D) acc = 1;
            end else begin m_state = 0; m_col = (m_col + 1) % 4; end
            2: if (r == 4'hF) begin m_state = 3; m_cnt = 1; end
            default: if (r == 4'hF) begin
                m_cnt++;
                if (m_cnt >= D) begin m_down = 0; m_state = 0; m_col = 0; end
            end else m_state = 2;
        endcase
        if (acc) begin
            m_ovr = m_valid && !a;
            m_code = 4'(m_row * 4 + m_col);
            m_valid = 1; m_down = 1; m_state = 2;
        end else if (a && m_valid) begin
            m_valid = 0; m_ovr = 0;
        end
    endtask

    task automatic reset_assert();
        @(negedge clk);
        reset = 0; rows = 4'hF; key_ack = 0;
        #1;
    endtask

    task automatic reset_release();
        @(negedge clk);
        reset = 1;
        @(posedge clk); #1;
        m_state = 0; m_col = 0; m_row = 0; m_cnt = 0;
        m_code = 0; m_valid = 0; m_down = 0; m_ovr = 0;
    endtask

    // one dwell: rows set just after a sample edge, ends just after the next sample edge
    task automatic dwell(input logic [3:0] r, input bit ack_mid, input bit ack_s);
        rows = r;
        @(posedge clk); #1 key_ack = ack_mid;
        @(posedge clk); #1 key_ack = 0;
        if (ack_mid && m_valid) begin m_valid = 0; m_ovr = 0; end
        @(posedge clk); #1 key_ack = ack_s;
        @(posedge clk); #1 key_ack = 0;
        m_sample(r, ack_s);
    endtask

    task automatic press(input int row, input int col, input bit ack_last);
        while (m_col != col) dwell(4'hF, 0, 0);
        repeat (D - 1) dwell(pat(row), 0, 0);
        dwell(pat(row), 0, ack_last);
    endtask

    task automatic test_reset();
        reset_assert();
        if (obs !== 11'h780) begin n_fail++; $display("FAIL reset_hold: got %h expected %h", obs, 11'h780); end
        n_checks++;
        reset_release();
        if (obs !== {4'b1110, 7'd0}) begin n_fail++; $display("FAIL reset_release: got %h expected %h", obs, {4'b1110, 7'd0}); end
        n_checks++;
    endtask

    task automatic test_scan();
        reset_assert();
        reset_release();
        for (int i = 0; i < 20; i++) begin
            if (obs !== {pat((i / 4) % 4), 7'd0}) begin
                n_fail++; $display("FAIL scan_step%0d: got %h expected %h", i, obs, {pat((i / 4) % 4), 7'd0});
            end
            n_checks++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_press();
        reset_assert();
        reset_release();
        dwell(4'hF, 0, 0);
        dwell(4'b1011, 0, 0);
        dwell(4'b1011, 0, 0);
        if (obs !== {4'b1101, 4'd0, 3'b000} || obs !== exp_bus()) begin
            n_fail++; $display("FAIL press_pending: got %h expected %h", obs, {4'b1101, 4'd0, 3'b000});
        end
        n_checks++;
        dwell(4'b1011, 0, 0);
        if (obs !== {4'b1101, 4'd9, 3'b110} || obs !== exp_bus()) begin
            n_fail++; $display("FAIL press_accept: got %h expected %h", obs, {4'b1101, 4'd9, 3'b110});
        end
        n_checks++;
        repeat (2) dwell(4'b1011, 0, 0);
        dwell(4'hF, 0, 0);
        dwell(4'hF, 0, 0);
        if (obs !== {4'b1101, 4'd9, 3'b110}) begin
            n_fail++; $display("FAIL press_held: got %h expected %h", obs, {4'b1101, 4'd9, 3'b110});
        end
        n_checks++;
        dwell(4'hF, 0, 0);
        if (obs !== {4'b1110, 4'd9, 3'b100} || obs !== exp_bus()) begin
            n_fail++; $display("FAIL press_release: got %h expected %h", obs, {4'b1110, 4'd9, 3'b100});
        end
        n_checks++;
        dwell(4'hF, 1, 0);
        if (obs !== {4'b1101, 4'd9, 3'b000} || obs !== exp_bus()) begin
            n_fail++; $display("FAIL press_ack: got %h expected %h", obs, {4'b1101, 4'd9, 3'b000});
        end
        n_checks++;
    endtask

    task automatic test_bounce();
        reset_assert();
        reset_release();
        dwell(4'hF, 0, 0);
        dwell(4'b1110, 0, 0);
        dwell(4'hF, 0, 0);
        if (obs !== {4'b1011, 7'd0} || obs !== exp_bus()) begin
            n_fail++; $display("FAIL bounce: got %h expected %h", obs, {4'b1011, 7'd0});
        end
        n_checks++;
    endtask

    task automatic test_multi();
        reset_assert();
        reset_release();
        for (int k = 0; k < 6; k++) begin
            dwell(4'b1001, 0, 0);
            if (obs !== {pat((k + 1) % 4), 7'd0} || obs !== exp_bus()) begin
                n_fail++; $display("FAIL multi_row%0d: got %h expected %h", k, obs, {pat((k + 1) % 4), 7'd0});
            end
            n_checks++;
        end
    endtask

    task automatic test_overrun();
        reset_assert();
        reset_release();
        press(2, 1, 0);
        repeat (D) dwell(4'hF, 0, 0);
        press(0, 3, 0);
        if (obs !== {4'b0111, 4'd3, 3'b111} || obs !== exp_bus()) begin
            n_fail++; $display("FAIL overrun_set: got %h expected %h", obs, {4'b0111, 4'd3, 3'b111});
        end
        n_checks++;
        repeat (D) dwell(4'hF, 0, 0);
        press(1, 2, 1);
        if (obs !== {4'b1011, 4'd6, 3'b110} || obs !== exp_bus()) begin
            n_fail++; $display("FAIL ack_with_accept: got %h expected %h", obs, {4'b1011, 4'd6, 3'b110});
        end
        n_checks++;
        dwell(4'hF, 1, 0);
        if (key_valid !== 1'b0 || overrun !== 1'b0) begin
            n_fail++; $display("FAIL ack_clear: got valid=%b ovr=%b expected 0 0", key_valid, overrun);
        end
        n_checks++;
    endtask

    task automatic test_reset_mid();
        reset_assert();
        reset_release();
        dwell(4'b1110, 0, 0);
        dwell(4'b1110, 0, 0);
        reset_assert();
        if (obs !== 11'h780) begin n_fail++; $display("FAIL mid_reset: got %h expected %h", obs, 11'h780); end
        n_checks++;
        reset_release();
        if (obs !== {4'b1110, 7'd0}) begin n_fail++; $display("FAIL mid_reset_restart: got %h expected %h", obs, {4'b1110, 7'd0}); end
        n_checks++;
        for (int k = 0; k < 4; k++) begin
            dwell(4'hF, 0, 0);
            if (obs !== {pat((k + 1) % 4), 7'd0} || obs !== exp_bus()) begin
                n_fail++; $display("FAIL mid_reset_stale%0d: got %h expected %h", k, obs, {pat((k + 1) % 4), 7'd0});
            end
            n_checks++;
        end
    endtask

    task automatic test_random();
        logic [3:0] p;
        int hold_left;
        reset_assert();
        reset_release();
        p = 4'hF;
        hold_left = 0;
        for (int n = 0; n < 300; n++) begin
            if (hold_left == 0) begin
                case ($urandom_range(0, 9))
                    0, 1, 2, 3: p = 4'hF;
                    8, 9:       p = 4'($urandom);
                    default:    p = pat($urandom_range(0, 3));
                endcase
                hold_left = $urandom_range(1, 6);
            end
            hold_left--;
            dwell(p, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
            if (obs !== exp_bus()) begin
                n_fail++; $display("FAIL random%0d rows=%b: got %h expected %h", n, p, obs, exp_bus());
            end
            n_checks++;
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_press();
        test_bounce();
        test_multi();
        test_overrun();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
